// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each pipeline segment adds SLICE-bit lookahead groups that ripple carry; the carry between segments is registered.

module cla_group #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co,
    output logic             cmsb
);
    logic [SLICE-1:0] g, p, c;
    logic             gg, pg;

    // Carry into bit n as a flat sum of products over the group's g/p terms.
    function automatic logic carry_at(input logic [SLICE-1:0] g_, input logic [SLICE-1:0] p_,
                                      input logic cin, input int n);
        logic             run, cy;
        logic [SLICE-1:0] tg, tp;
        run = 1'b1;
        cy  = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            tg  = g_ >> i;
            tp  = p_ >> i;
            cy  = cy | (run & tg[0]);
            run = run & tp[0];
        end
        return cy | (run & cin);
    endfunction

    assign g = a & b;
    assign p = a ^ b;

    for (genvar j = 0; j < SLICE; j++) begin : g_carry
        assign c[j] = carry_at(g, p, ci, j);
    end

    assign gg   = carry_at(g, p, 1'b0, SLICE);
    assign pg   = &p;
    assign co   = gg | (pg & ci);
    assign cmsb = c[SLICE-1];
    assign sum  = p ^ c;
endmodule

module cla_segment #(
    parameter int SEG_W = 16,
    parameter int SLICE = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] sum,
    output logic             co,
    output logic             cmsb
);
    localparam int NG = SEG_W / SLICE;

    logic gc [NG+1];
    logic gm [NG];

    assign gc[0] = ci;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_group #(.SLICE(SLICE)) u_grp (
            .a    (a[g*SLICE +: SLICE]),
            .b    (b[g*SLICE +: SLICE]),
            .ci   (gc[g]),
            .sum  (sum[g*SLICE +: SLICE]),
            .co   (gc[g+1]),
            .cmsb (gm[g])
        );
    end

    assign co   = gc[NG];
    assign cmsb = gm[NG-1];
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int SLICE  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             CI,
    input  logic             Sub,
    input  logic             Enable,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out,
    output logic             CO,
    output logic             OV,
    output logic             Zero
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             advance;
    logic [STAGES:0]  vld_pipe;
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_sum   [STAGES];
    logic [WIDTH-1:0] nxt_sum  [STAGES];
    logic             st_c     [STAGES];
    logic             st_en    [STAGES];
    logic             seg_co   [STAGES];
    logic             seg_cmsb [STAGES];

    assign advance  = ~vld_pipe[STAGES] | Out_Ready;
    assign In_Ready = advance;

    // Subtraction is A + ~B + 1; CI only matters when adding.
    assign vld_pipe[0] = In_Valid;
    assign st_a[0]     = In1;
    assign st_b[0]     = Sub ? ~In2 : In2;
    assign st_c[0]     = Sub | CI;
    assign st_sum[0]   = '0;
    assign st_en[0]    = Enable;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] seg_sum;

        cla_segment #(.SEG_W(SEG), .SLICE(SLICE)) u_seg (
            .a    (st_a[k][k*SEG +: SEG]),
            .b    (st_b[k][k*SEG +: SEG]),
            .ci   (st_c[k]),
            .sum  (seg_sum),
            .co   (seg_co[k]),
            .cmsb (seg_cmsb[k])
        );

        // Accumulated result only holds bits below this segment, so OR-in is a merge.
        assign nxt_sum[k] = st_sum[k] | (WIDTH'(seg_sum) << (k * SEG));

        if (k < LAST) begin : g_reg
            logic             r_v, r_c, r_en;
            logic [WIDTH-1:0] r_a, r_b, r_sum;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_en  <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (advance) begin
                    r_v   <= vld_pipe[k];
                    r_c   <= seg_co[k];
                    r_en  <= st_en[k];
                    r_a   <= st_a[k];
                    r_b   <= st_b[k];
                    r_sum <= nxt_sum[k];
                end
            end

            assign vld_pipe[k+1] = r_v;
            assign st_c[k+1]     = r_c;
            assign st_en[k+1]    = r_en;
            assign st_a[k+1]     = r_a;
            assign st_b[k+1]     = r_b;
            assign st_sum[k+1]   = r_sum;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_pipe[STAGES] <= 1'b0;
            Out              <= '0;
            CO               <= 1'b0;
            OV               <= 1'b0;
            Zero             <= 1'b0;
        end else if (advance) begin
            vld_pipe[STAGES] <= vld_pipe[LAST];
            if (vld_pipe[LAST]) begin
                if (st_en[LAST]) begin
                    Out  <= nxt_sum[LAST];
                    CO   <= seg_co[LAST];
                    OV   <= seg_cmsb[LAST] ^ seg_co[LAST];
                    Zero <= ~|nxt_sum[LAST];
                end else begin
                    Out  <= '0;
                    CO   <= 1'b0;
                    OV   <= 1'b0;
                    Zero <= 1'b1;
                end
            end
        end
    end

    assign Out_Valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: vector table, streaming/stall/reset sequences, random traffic
// against an arithmetic reference, plus a 64-bit / 4-stage instance.

module tb_pipelined_cla_adder;
    typedef struct {
        logic [31:0] out;
        logic        co, ov, zero;
    } res_t;

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sub, en;
        logic [31:0] out;
        logic        co, ov, zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, ci, sub, en, out_valid, out_ready, co, ov, zero;
    logic [31:0] in1, in2, out;

    logic        b_in_valid, b_in_ready, b_ci, b_sub, b_en, b_out_valid, b_out_ready, b_co, b_ov, b_zero;
    logic [63:0] b_in1, b_in2, b_out;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   consumed = 0;
    int   first_pop, last_pop;
    res_t q[$];
    logic stalled = 1'b0;
    logic [34:0] held;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .SLICE(4), .STAGES(2)) dut (
        .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
        .In1(in1), .In2(in2), .CI(ci), .Sub(sub), .Enable(en),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out(out), .CO(co), .OV(ov), .Zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(64), .SLICE(8), .STAGES(4)) dut64 (
        .Clk(clk), .Rst_n(rst_n), .In_Valid(b_in_valid), .In_Ready(b_in_ready),
        .In1(b_in1), .In2(b_in2), .CI(b_ci), .Sub(b_sub), .Enable(b_en),
        .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Out(b_out), .CO(b_co), .OV(b_ov), .Zero(b_zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values.
    function automatic res_t model_op(input logic [31:0] a, input logic [31:0] b,
                                      input logic c, input logic s, input logic e);
        res_t             r;
        longint           sa, sb, sr;
        longint unsigned  ua, ub, ur;
        if (!e) begin
            r.out = 32'h0; r.co = 1'b0; r.ov = 1'b0; r.zero = 1'b1;
            return r;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (s) begin
            ur   = ua - ub;
            r.co = (ua >= ub);
            sr   = sa - sb;
        end else begin
            ur   = ua + ub + {63'h0, c};
            r.co = (ur >= 64'h1_0000_0000);
            sr   = sa + sb + longint'(c);
        end
        r.out  = ur[31:0];
        r.ov   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.out == 32'h0);
        return r;
    endfunction

    // One clock: drive, check/record the pre-edge handshakes, advance to just after the edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input logic e, input logic ordy,
                         output logic rdy);
        res_t exp;
        in_valid = v; in1 = a; in2 = b; ci = c; sub = s; en = e; out_ready = ordy;
        #1;
        rdy = in_ready;
        if (stalled) begin
            chk("stall_hold", {co, ov, zero, out}, held);
            chk("stall_valid", out_valid, 1'b1);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", out_valid, 1'b0);
            end else begin
                exp = q.pop_front();
                chk("out", out, exp.out);
                chk("co", co, exp.co);
                chk("ov", ov, exp.ov);
                chk("zero", zero, exp.zero);
                consumed++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        stalled = out_valid && !out_ready;
        held    = {co, ov, zero, out};
        if (in_valid && in_ready) q.push_back(model_op(a, b, c, s, e));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single operation into an idle pipeline; checks exact 2-cycle latency.
    task automatic apply_one(input vec_t v, input int idx);
        in_valid = 1'b1; in1 = v.a; in2 = v.b; ci = v.ci; sub = v.sub; en = v.en; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("vec%0d_early", idx), out_valid, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
        chk($sformatf("vec%0d_out", idx), out, v.out);
        chk($sformatf("vec%0d_co", idx), co, v.co);
        chk($sformatf("vec%0d_ov", idx), ov, v.ov);
        chk($sformatf("vec%0d_zero", idx), zero, v.zero);
    endtask

    initial begin
        vec_t        tbl[9];
        logic        rdy;
        logic [31:0] ra, rb;
        logic [64:0] wide;
        int          pushed;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h12345679, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in1 = '0; in2 = '0; ci = 1'b0; sub = 1'b0; en = 1'b1; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_ci = 1'b0; b_sub = 1'b0; b_en = 1'b1; b_out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_out", out, 32'h0);
        chk("rst_flags", {co, ov, zero}, 3'b000);
        chk("rst64_valid", b_out_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1'b1);

        for (int i = 0; i < 9; i++) apply_one(tbl[i], i);
        @(posedge clk); #1;

        // Back-to-back stream of 8, including a 15->16 carry crossing.
        first_pop = -1; consumed = 0;
        for (int i = 0; i < 8; i++) begin
            ra = (i == 2) ? 32'h0000FFFF : $urandom;
            rb = (i == 2) ? 32'h00000001 : ((i == 5) ? (32'h0000FFFF - (ra & 32'h0000FFFF) + 1) : $urandom);
            cycle(1'b1, ra, rb, i[0], (i == 6), 1'b1, 1'b1, rdy);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        chk("stream_count", consumed, 8);
        chk("stream_consecutive", last_pop - first_pop, 7);
        chk("stream_drained", q.size(), 0);

        // Stall with full pipeline for 3 cycles, then drain.
        consumed = 0; pushed = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
            pushed += int'(rdy);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
            chk("stall_in_ready", rdy, 1'b0);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        chk("stall_no_loss", consumed, pushed);
        chk("stall_drained", q.size(), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0), rdy);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        chk("random_drained", q.size(), 0);

        // Reset with two operations in flight.
        cycle(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        cycle(1'b1, 32'h33333333, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_out", out, 32'h0);
        chk("midrst_flags", {co, ov, zero}, 3'b000);
        q.delete();
        stalled = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, rdy);
            chk("midrst_no_stale", out_valid, 1'b0);
        end

        // 64-bit, 4-stage instance.
        b_in1 = '1; b_in2 = 64'h1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w64_early", b_out_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("w64_valid", b_out_valid, 1'b1);
        chk("w64_out", b_out, 64'h0);
        chk("w64_flags", {b_co, b_ov, b_zero}, 3'b101);
        for (int i = 0; i < 6; i++) begin
            b_in1 = {$urandom, $urandom}; b_in2 = {$urandom, $urandom}; b_sub = i[0]; b_ci = i[1];
            wide = b_sub ? ({1'b0, b_in1} + {1'b0, ~b_in2} + 65'h1) : ({1'b0, b_in1} + {1'b0, b_in2} + {64'h0, b_ci});
            b_in_valid = 1'b1;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("w64_rand_valid", b_out_valid, 1'b1);
            chk("w64_rand_out", b_out, wide[63:0]);
            chk("w64_rand_co", b_co, b_sub ? (b_in1 >= b_in2) : wide[64]);
        end
        b_in1 = 64'h5; b_in2 = 64'h6; b_sub = 1'b0; b_in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("w64_midrst_valid", b_out_valid, 1'b0);
        chk("w64_midrst_out", b_out, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("w64_no_stale", b_out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
